// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU select codes and the
// forwarding-source selector used by the ID/EX stage.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int SELW = 4;

  localparam logic [SELW-1:0] ALU_AND = 4'b0000;
  localparam logic [SELW-1:0] ALU_OR  = 4'b0001;
  localparam logic [SELW-1:0] ALU_XOR = 4'b0010;
  localparam logic [SELW-1:0] ALU_SLT = 4'b0011;
  localparam logic [SELW-1:0] ALU_ADD = 4'b0111;
  localparam logic [SELW-1:0] ALU_SUB = 4'b1000;

  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX stage, the downstream forwarding sources
// and the ALU. master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_if #(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int REGW = pipe_pkg::REGW,
  parameter int SELW = pipe_pkg::SELW
);
  logic            idValid, idReady;
  logic [XLEN-1:0] idPc;
  logic [REGW-1:0] idRs1, idRs2, idRd;
  logic [XLEN-1:0] idRs1Data, idRs2Data, idImm;
  logic            idUsePc, idUseImm;
  logic [SELW-1:0] idAluSel;
  logic            idRegWrite, idMemRead;
  logic            flush;
  logic [REGW-1:0] memRd;
  logic            memRegWrite;
  logic [XLEN-1:0] memResult;
  logic [REGW-1:0] wbRd;
  logic            wbRegWrite;
  logic [XLEN-1:0] wbData;
  logic            exValid;
  logic [XLEN-1:0] exInputA, exInputB;
  logic [SELW-1:0] exAluSel;
  logic [REGW-1:0] exRd;
  logic            exRegWrite, exMemRead;
  logic [XLEN-1:0] exPc, exStoreData;

  modport master (
    output idValid, idPc, idRs1, idRs2, idRd, idRs1Data, idRs2Data, idImm,
           idUsePc, idUseImm, idAluSel, idRegWrite, idMemRead, flush,
           memRd, memRegWrite, memResult, wbRd, wbRegWrite, wbData,
    input  idReady, exValid, exInputA, exInputB, exAluSel, exRd,
           exRegWrite, exMemRead, exPc, exStoreData
  );

  modport slave (
    input  idValid, idPc, idRs1, idRs2, idRd, idRs1Data, idRs2Data, idImm,
           idUsePc, idUseImm, idAluSel, idRegWrite, idMemRead, flush,
           memRd, memRegWrite, memResult, wbRd, wbRegWrite, wbData,
    output idReady, exValid, exInputA, exInputB, exAluSel, exRd,
           exRegWrite, exMemRead, exPc, exStoreData
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand's forwarding mux: newest producer wins (MEM over WB over the
// value latched at ID/EX). x0 is never forwarded.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int REGW = pipe_pkg::REGW
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] latched,
  input  logic [REGW-1:0] memRd,
  input  logic            memRegWrite,
  input  logic [XLEN-1:0] memResult,
  input  logic [REGW-1:0] wbRd,
  input  logic            wbRegWrite,
  input  logic [XLEN-1:0] wbData,
  output logic [XLEN-1:0] val
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (memRegWrite && memRd != '0 && memRd == rs)
      sel = FWD_MEM;
    else if (wbRegWrite && wbRd != '0 && wbRd == rs)
      sel = FWD_WB;
  end

  always_comb begin
    case (sel)
      FWD_MEM: val = memResult;
      FWD_WB:  val = wbData;
      default: val = latched;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select, MEM/WB forwarding,
// load-use stall insertion and branch-flush squash.
module id_ex_stage #(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int REGW = pipe_pkg::REGW,
  parameter int SELW = pipe_pkg::SELW
) (
  input  logic clk,
  input  logic rst,
  id_ex_if.slave bus
);

  localparam int NFWD = 3;  // operand A, operand B, store data

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic            usePc;
    logic            useImm;
    logic [SELW-1:0] aluSel;
    logic            regWrite;
    logic            memRead;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic    stall, take;
  logic    wbHit1, wbHit2;

  // A load in EX whose rd is consumed by ID; operand A reading the PC
  // does not depend on rs1.
  assign stall = ex_q.valid & ex_q.memRead & (ex_q.rd != '0) & bus.idValid &
                 (((ex_q.rd == bus.idRs1) & ~bus.idUsePc) | (ex_q.rd == bus.idRs2));

  assign bus.idReady = bus.flush | ~stall;
  assign take        = bus.idValid & ~stall & ~bus.flush;

  // WB writes the register file in the same cycle ID reads it.
  assign wbHit1 = bus.wbRegWrite & (bus.wbRd != '0) & (bus.wbRd == bus.idRs1);
  assign wbHit2 = bus.wbRegWrite & (bus.wbRd != '0) & (bus.wbRd == bus.idRs2);

  always_comb begin
    ex_d = '0;
    if (take) begin
      ex_d.valid    = 1'b1;
      ex_d.pc       = bus.idPc;
      ex_d.rs1      = bus.idRs1;
      ex_d.rs2      = bus.idRs2;
      ex_d.rd       = bus.idRd;
      ex_d.rs1Data  = wbHit1 ? bus.wbData : bus.idRs1Data;
      ex_d.rs2Data  = wbHit2 ? bus.wbData : bus.idRs2Data;
      ex_d.imm      = bus.idImm;
      ex_d.usePc    = bus.idUsePc;
      ex_d.useImm   = bus.idUseImm;
      ex_d.aluSel   = bus.idAluSel;
      ex_d.regWrite = bus.idRegWrite;
      ex_d.memRead  = bus.idMemRead;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  logic [NFWD-1:0][REGW-1:0] fwd_rs;
  logic [NFWD-1:0][XLEN-1:0] fwd_in;
  logic [NFWD-1:0][XLEN-1:0] fwd_out;

  assign fwd_rs[0] = ex_q.rs1;
  assign fwd_in[0] = ex_q.rs1Data;
  assign fwd_rs[1] = ex_q.rs2;
  assign fwd_in[1] = ex_q.rs2Data;
  assign fwd_rs[2] = ex_q.rs2;
  assign fwd_in[2] = ex_q.rs2Data;

  for (genvar g = 0; g < NFWD; g++) begin : g_fwd
    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd (
      .rs          (fwd_rs[g]),
      .latched     (fwd_in[g]),
      .memRd       (bus.memRd),
      .memRegWrite (bus.memRegWrite),
      .memResult   (bus.memResult),
      .wbRd        (bus.wbRd),
      .wbRegWrite  (bus.wbRegWrite),
      .wbData      (bus.wbData),
      .val         (fwd_out[g])
    );
  end

  assign bus.exValid     = ex_q.valid;
  assign bus.exInputA    = ex_q.usePc  ? ex_q.pc  : fwd_out[0];
  assign bus.exInputB    = ex_q.useImm ? ex_q.imm : fwd_out[1];
  assign bus.exStoreData = fwd_out[2];
  assign bus.exAluSel    = ex_q.aluSel;
  assign bus.exRd        = ex_q.rd;
  assign bus.exRegWrite  = ex_q.regWrite;
  assign bus.exMemRead   = ex_q.memRead;
  assign bus.exPc        = ex_q.pc;

endmodule
